trajectory_point_encoder: RTL
=============================

TRAJECTORY_POINT_ENCODER -- requirements
Module: trajectory_point_encoder

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, meaning visible pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 480, meaning visible pixel rows.
REQ-003 SHALL have parameter STROBE_HIGH, default 2, meaning cycles trajectory_memloc_enable is held high per point (min 1).
REQ-004 SHALL have parameter STROBE_LOW, default 2, meaning minimum low cycles after each strobe (min 1).
REQ-005 SHALL have parameter DECIM, default 1, meaning keep one of every DECIM accepted in-bounds, non-duplicate points.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning encoded-address buffer entries (power of two).
REQ-007 clock  input  1  sole clock, all state on rising edge.
REQ-008 resetn  input  1  asynchronous, active-low reset.
REQ-009 pt_x  input  10  missile pixel column.
REQ-010 pt_y  input  9  missile pixel row.
REQ-011 pt_valid  input  1  pt_x/pt_y hold a point.
REQ-012 pt_ready  output  1  point accepted on this edge if pt_valid.
REQ-013 clear  input  1  single-cycle pulse: start a new trajectory.
REQ-014 trajectory_memloc  output  19  linear pixel address y*SCREEN_W+x.
REQ-015 trajectory_memloc_enable  output  1  write strobe to the trajectory writer.
REQ-016 dropped_count  output  16  out-of-bounds points discarded since reset.
REQ-017 busy  output  1  any point in pipeline, FIFO or strobe FSM.

Function
REQ-018 Handshake: point accepted on rising edge where pt_valid=1 and pt_ready=1; pt_ready=1 iff (FIFO occupancy + encode-stage occupancy) < FIFO_DEPTH.
REQ-019 Out-of-bounds (pt_x>=SCREEN_W or pt_y>=SCREEN_H): accepted, discarded, dropped_count+1, saturating at 65535.
REQ-020 Duplicate: in-bounds point equal to last kept point is discarded; not counted in dropped_count; not advancing decimation counter.
REQ-021 Decimation: counter 0..DECIM-1 advances per in-bounds non-duplicate point; point kept only when counter=0; counter wraps DECIM-1 -> 0.
REQ-022 Encode: address = y*640+x via shifts/adds ((y<<9)+(y<<7)+x for default), 19-bit unsigned, registered in one encode stage, then written to FIFO.
REQ-023 Latency: with FIFO empty and FSM IDLE, point accepted at edge k drives trajectory_memloc and enable=1 after edge k+2.
REQ-024 Strobe FSM states IDLE, HIGH, LOW.
REQ-025 IDLE: if FIFO non-empty, pop head into trajectory_memloc, go HIGH; else stay.
REQ-026 HIGH: enable=1 for exactly STROBE_HIGH cycles, then LOW.
REQ-027 LOW: enable=0 for exactly STROBE_LOW cycles, then IDLE.
REQ-028 trajectory_memloc stable from entry to HIGH until exit from LOW; holds last value in IDLE.
REQ-029 enable is a register output, glitch-free (downstream uses its edges as clocks).
REQ-030 clear: invalidates duplicate memory and zeroes decimation counter; does not flush FIFO, abort strobe, or reset dropped_count; clear and accept on same edge -> clear applies first, the point is treated as first of the new trajectory.
REQ-031 Simultaneous FIFO push and pop on one edge: both occur, occupancy unchanged.
REQ-032 busy=1 iff encode stage valid, or FIFO non-empty, or FSM not IDLE.

Reset
REQ-033 resetn=0 immediately (asynchronously) forces: enable=0, trajectory_memloc=0, FSM IDLE, FIFO empty, encode stage empty, duplicate memory invalid, decimation counter 0, dropped_count 0, busy=0.
REQ-034 Reset asserted mid-strobe ends the strobe at once; buffered points are lost.
REQ-035 After resetn deasserts, pt_ready=1 on the first clock edge.

Verification
REQ-036 Single point (10,2) at edge k -> memloc=1290, enable=1 after edges k+2,k+3, 0 for next 2 cycles, busy falls after that.
REQ-037 Corner (639,479) -> memloc=307199; (640,0) and (0,480) -> no strobe, dropped_count=2.
REQ-038 (5,5) three times back to back -> one strobe memloc=3205; clear then (5,5) -> second strobe 3205.
REQ-039 Burst of 8 valid distinct points with pt_valid held -> pt_ready deasserts after 4 in flight, all 8 strobed in order, none lost, each strobe 2 high/2 low.
REQ-040 DECIM=3, points x=0..5 at y=0 -> strobes only memloc 0 and 3.
REQ-041 resetn low during HIGH with 2 points buffered -> enable drops asynchronously, no further strobes after release, dropped_count=0.

Source files
------------

// File: rtl/trajectory_point_encoder.sv
// Filters, decimates and encodes missile pixel points into linear addresses,
// then replays them as timed write strobes to the trajectory writer.
module trajectory_point_encoder #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int STROBE_HIGH = 2,
    parameter int STROBE_LOW  = 2,
    parameter int DECIM       = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [9:0]  pt_x,
    input  logic [8:0]  pt_y,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic        clear,
    output logic [18:0] trajectory_memloc,
    output logic        trajectory_memloc_enable,
    output logic [15:0] dropped_count,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [31:0] X_LIM = 32'(SCREEN_W);
    localparam logic [31:0] Y_LIM = 32'(SCREEN_H);
    localparam logic [18:0] W19   = 19'(SCREEN_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    logic        accept, in_bounds, dup, novel, keep, push, pop;
    logic        dup_valid;
    logic [9:0]  last_x;
    logic [8:0]  last_y;
    logic [15:0] dec_cnt, dec_eff;
    logic        enc_valid;
    logic [18:0] enc_addr;
    logic [18:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [1:0]  state;
    logic [15:0] phase_cnt;

    // clear is folded in combinationally so a point arriving with it is judged
    // against an empty duplicate memory and a zeroed decimation counter.
    always_comb begin
        pt_ready  = (fifo_count + CW'(enc_valid)) < CW'(FIFO_DEPTH);
        accept    = pt_valid && pt_ready;
        in_bounds = (32'(pt_x) < X_LIM) && (32'(pt_y) < Y_LIM);
        dup       = dup_valid && !clear && (pt_x == last_x) && (pt_y == last_y);
        dec_eff   = clear ? '0 : dec_cnt;
        novel     = accept && in_bounds && !dup;
        keep      = novel && (dec_eff == '0);
        push      = enc_valid;
        pop       = (state == ST_IDLE) && (fifo_count != '0);
        busy      = enc_valid || (fifo_count != '0) || (state != ST_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dup_valid     <= 1'b0;
            last_x        <= '0;
            last_y        <= '0;
            dec_cnt       <= '0;
            dropped_count <= '0;
            enc_valid     <= 1'b0;
            enc_addr      <= '0;
        end else begin
            if (keep) begin
                dup_valid <= 1'b1;
                last_x    <= pt_x;
                last_y    <= pt_y;
            end else if (clear) begin
                dup_valid <= 1'b0;
            end
            if (novel)
                dec_cnt <= (dec_eff == 16'(DECIM - 1)) ? '0 : dec_eff + 16'd1;
            else if (clear)
                dec_cnt <= '0;
            if (accept && !in_bounds && (dropped_count != '1))
                dropped_count <= dropped_count + 16'd1;
            enc_valid <= keep;
            if (keep)
                enc_addr <= 19'(pt_y) * W19 + 19'(pt_x);
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= enc_addr;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state                    <= ST_IDLE;
            phase_cnt                <= '0;
            trajectory_memloc        <= '0;
            trajectory_memloc_enable <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        trajectory_memloc        <= fifo_mem[rd_ptr];
                        trajectory_memloc_enable <= 1'b1;
                        phase_cnt                <= '0;
                        state                    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_cnt == 16'(STROBE_HIGH - 1)) begin
                        trajectory_memloc_enable <= 1'b0;
                        phase_cnt                <= '0;
                        state                    <= ST_LOW;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                ST_LOW: begin
                    if (phase_cnt == 16'(STROBE_LOW - 1))
                        state <= ST_IDLE;
                    else
                        phase_cnt <= phase_cnt + 16'd1;
                end
                default: begin
                    trajectory_memloc_enable <= 1'b0;
                    state                    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
